// File: rtl/ysyx_22051013_hzd_ctl_pkg.sv
// Shared definitions for the pipeline hazard / fence.i controller:
// FSM state encoding, stall/flush bit positions and the drain watchdog default.
package ysyx_22051013_hzd_ctl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDrain   = 2'd1,
    StIcflush = 2'd2,
    StRedir   = 2'd3
  } hzd_state_e;

  // stall_o bit positions (hold a stage)
  localparam int unsigned STG_IF = 0;
  localparam int unsigned STG_ID = 1;
  localparam int unsigned STG_EX = 2;
  localparam int unsigned STG_LS = 3;

  // flush_o bit positions (bubble into a pipeline register)
  localparam int unsigned FL_IF_ID = 0;
  localparam int unsigned FL_ID_EX = 1;
  localparam int unsigned FL_EX_LS = 2;
  localparam int unsigned FL_LS_WB = 3;

  localparam int unsigned DRAIN_MAX_DEF = 255;

endpackage

// File: rtl/ysyx_22051013_hzd_wdog.sv
// Drain watchdog: counts consecutive enabled cycles and flags the cycle on which
// the count would reach DRAIN_MAX. Clears whenever the enable drops.
module ysyx_22051013_hzd_wdog
  import ysyx_22051013_hzd_ctl_pkg::*;
#(
  parameter int unsigned DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ena,
  output logic o_expire
);

  localparam logic [7:0] CNT_LAST = 8'(DRAIN_MAX - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (i_ena) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  // Expire on the DRAIN_MAX-th enabled cycle so the exit lands exactly on the limit
  assign o_expire = i_ena && (r_cnt == CNT_LAST);

endmodule

// File: rtl/ysyx_22051013_hzd_ctl.sv
// Pipeline hazard controller: prioritised stall/flush in normal running, plus the
// fence.i sequence (drain pipeline, invalidate icache, redirect fetch to pc+4).
module ysyx_22051013_hzd_ctl
  import ysyx_22051013_hzd_ctl_pkg::*;
#(
  parameter int unsigned PC_W      = 64,
  parameter int unsigned DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_stall_req,
  input  logic            id_jump_ena,
  input  logic            id_fencei,
  input  logic [PC_W-1:0] id_pc,
  input  logic            ex_busy,
  input  logic            ls_busy,
  input  logic            pipe_empty,
  input  logic            ic_flush_done,
  output logic [3:0]      stall_o,
  output logic [3:0]      flush_o,
  output logic            ic_flush_req,
  output logic            redir_ena,
  output logic [PC_W-1:0] redir_pc,
  output logic            fencei_err
);

  hzd_state_e      r_state;
  hzd_state_e      w_state_d;
  logic [PC_W-1:0] r_redir_pc;
  logic            r_err;
  logic            w_capture;
  logic            w_drain;
  logic            w_expire;
  logic            w_timeout;

  assign w_drain   = (r_state == StDrain);
  assign w_timeout = w_expire && !pipe_empty;

  ysyx_22051013_hzd_wdog #(
    .DRAIN_MAX(DRAIN_MAX)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .i_ena   (w_drain),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StRun;
      r_redir_pc <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_capture) begin
        r_redir_pc <= id_pc + PC_W'(4);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_capture    = 1'b0;
    stall_o      = 4'b0000;
    flush_o      = 4'b0000;
    ic_flush_req = 1'b0;
    redir_ena    = 1'b0;
    unique case (r_state)
      StRun: begin
        if (ls_busy) begin
          stall_o = 4'b1111;
        end else if (ex_busy) begin
          stall_o = 4'b0111;
          flush_o = 4'b0100;
        end else if (id_stall_req) begin
          stall_o = 4'b0011;
          flush_o = 4'b0010;
        end else if (id_jump_ena) begin
          flush_o = 4'b0001;
        end else if (id_fencei) begin
          w_capture = 1'b1;
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        // Front end frozen with a bubble behind it; back end keeps draining
        stall_o[STG_IF]   = 1'b1;
        stall_o[STG_ID]   = 1'b1;
        stall_o[STG_EX]   = ex_busy || ls_busy;
        stall_o[STG_LS]   = ls_busy;
        flush_o[FL_ID_EX] = 1'b1;
        flush_o[FL_EX_LS] = ex_busy && !ls_busy;
        if (pipe_empty || w_expire) begin
          w_state_d = StIcflush;
        end
      end
      StIcflush: begin
        ic_flush_req = 1'b1;
        stall_o      = 4'b0011;
        if (ic_flush_done) begin
          w_state_d = StRedir;
        end
      end
      StRedir: begin
        redir_ena = 1'b1;
        flush_o   = 4'b0001;
        w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
    if (!rst) begin
      stall_o      = 4'b0000;
      flush_o      = 4'b0000;
      ic_flush_req = 1'b0;
      redir_ena    = 1'b0;
    end
  end

  assign redir_pc   = r_redir_pc;
  assign fencei_err = r_err;

endmodule

// File: tb/tb_ysyx_22051013_hzd_ctl.sv
// Directed self-checking bench for the hazard / fence.i controller.
module tb_ysyx_22051013_hzd_ctl;

  logic        clk;
  logic        rst;
  logic        id_stall_req;
  logic        id_jump_ena;
  logic        id_fencei;
  logic [63:0] id_pc;
  logic        ex_busy;
  logic        ls_busy;
  logic        pipe_empty;
  logic        ic_flush_done;
  logic [3:0]  stall_o;
  logic [3:0]  flush_o;
  logic        ic_flush_req;
  logic        redir_ena;
  logic [63:0] redir_pc;
  logic        fencei_err;

  int n_tests;
  int n_fail;

  ysyx_22051013_hzd_ctl #(
    .PC_W     (64),
    .DRAIN_MAX(255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_stall_req (id_stall_req),
    .id_jump_ena  (id_jump_ena),
    .id_fencei    (id_fencei),
    .id_pc        (id_pc),
    .ex_busy      (ex_busy),
    .ls_busy      (ls_busy),
    .pipe_empty   (pipe_empty),
    .ic_flush_done(ic_flush_done),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .ic_flush_req (ic_flush_req),
    .redir_ena    (redir_ena),
    .redir_pc     (redir_pc),
    .fencei_err   (fencei_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle mid-cycle, away from the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_stall_req  = 1'b0;
    id_jump_ena   = 1'b0;
    id_fencei     = 1'b0;
    id_pc         = 64'h0;
    ex_busy       = 1'b0;
    ls_busy       = 1'b0;
    pipe_empty    = 1'b0;
    ic_flush_done = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] st, input logic [3:0] fl,
                           input logic icr, input logic rde);
    check_val({tag, ".stall"}, 64'(stall_o), 64'(st));
    check_val({tag, ".flush"}, 64'(flush_o), 64'(fl));
    check_val({tag, ".icreq"}, 64'(ic_flush_req), 64'(icr));
    check_val({tag, ".redir"}, 64'(redir_ena), 64'(rde));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr_in();
    rst = 1'b0;
    #2;
    // Outputs forced quiet while in reset, even with a busy request present
    ls_busy = 1'b1;
    #1;
    check_out("rst_hold", 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    clr_in();
    #1;
    check_val("rst_redir_pc", redir_pc, 64'h0);
    check_val("rst_err", 64'(fencei_err), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("idle", 4'h0, 4'h0, 1'b0, 1'b0);

    ls_busy = 1'b1; ex_busy = 1'b1; #1;
    check_out("ls_ex", 4'hF, 4'h0, 1'b0, 1'b0);
    ls_busy = 1'b0; #1;
    check_out("ex_only", 4'h7, 4'h4, 1'b0, 1'b0);
    // fence.i under ex_busy must not be taken
    id_fencei = 1'b1; id_pc = 64'h1000; #1;
    check_out("fencei_blocked", 4'h7, 4'h4, 1'b0, 1'b0);
    tick();
    clr_in(); #1;
    check_out("still_run", 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("no_capture", redir_pc, 64'h0);

    id_stall_req = 1'b1; id_jump_ena = 1'b1; #1;
    check_out("stall_over_jump", 4'h3, 4'h2, 1'b0, 1'b0);
    tick();
    id_stall_req = 1'b0; #1;
    check_out("jump_alone", 4'h0, 4'h1, 1'b0, 1'b0);
    tick();
    clr_in();

    // fence.i: 3 drain cycles, 2 icache flush cycles
    id_fencei = 1'b1; id_pc = 64'h8000_0010; #1;
    check_out("fencei_issue", 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    clr_in();
    id_jump_ena = 1'b1; id_fencei = 1'b1; #1;
    check_out("drain1", 4'h3, 4'h2, 1'b0, 1'b0);
    check_val("pc_captured", redir_pc, 64'h8000_0014);
    tick();
    clr_in();
    ex_busy = 1'b1; #1;
    check_out("drain2_ex", 4'h7, 4'h6, 1'b0, 1'b0);
    tick();
    ex_busy = 1'b0; pipe_empty = 1'b1; #1;
    check_out("drain3", 4'h3, 4'h2, 1'b0, 1'b0);
    tick();
    pipe_empty = 1'b0; #1;
    check_out("icflush1", 4'h3, 4'h0, 1'b1, 1'b0);
    tick();
    ic_flush_done = 1'b1; #1;
    check_out("icflush2", 4'h3, 4'h0, 1'b1, 1'b0);
    tick();
    ic_flush_done = 1'b0; #1;
    check_out("redir", 4'h0, 4'h1, 1'b0, 1'b1);
    check_val("redir_pc", redir_pc, 64'h8000_0014);
    tick();
    #1;
    check_out("after_redir", 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("pc_hold", redir_pc, 64'h8000_0014);

    // pc+4 wraps to zero
    id_fencei = 1'b1; id_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    clr_in();
    pipe_empty = 1'b1; #1;
    check_val("wrap_pc", redir_pc, 64'h0);
    tick();
    pipe_empty = 1'b0; ic_flush_done = 1'b1;
    tick();
    ic_flush_done = 1'b0; #1;
    check_out("wrap_redir", 4'h0, 4'h1, 1'b0, 1'b1);
    check_val("wrap_redir_pc", redir_pc, 64'h0);
    tick();

    // Watchdog: pipe never empties
    id_fencei = 1'b1; id_pc = 64'h100;
    tick();
    clr_in();
    for (int i = 0; i < 254; i++) tick();
    #1;
    check_out("drain255", 4'h3, 4'h2, 1'b0, 1'b0);
    check_val("err_before", 64'(fencei_err), 64'h0);
    tick();
    check_val("err_after", 64'(fencei_err), 64'h1);
    check_out("wdog_icflush", 4'h3, 4'h0, 1'b1, 1'b0);
    ic_flush_done = 1'b1;
    tick();
    ic_flush_done = 1'b0; #1;
    check_out("wdog_redir", 4'h0, 4'h1, 1'b0, 1'b1);
    check_val("wdog_pc", redir_pc, 64'h104);
    tick();
    check_val("err_sticky", 64'(fencei_err), 64'h1);

    // Reset in the middle of ICFLUSH
    id_fencei = 1'b1; id_pc = 64'h200;
    tick();
    clr_in();
    pipe_empty = 1'b1;
    tick();
    pipe_empty = 1'b0; #1;
    check_out("pre_rst_icflush", 4'h3, 4'h0, 1'b1, 1'b0);
    rst = 1'b0; #1;
    check_out("rst_mid_fence", 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1; #1;
    check_out("post_rst", 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("post_rst_err", 64'(fencei_err), 64'h0);
    check_val("post_rst_pc", redir_pc, 64'h0);
    id_jump_ena = 1'b1; #1;
    check_out("post_rst_run", 4'h0, 4'h1, 1'b0, 1'b0);
    tick();
    clr_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_hzd_ctl.md
YSYX_22051013_HZD_CTL -- requirements
Module: ysyx_22051013_hzd_ctl

Interface
REQ-001 Parameter PC_W, default 64, PC/redirect width.
REQ-002 Parameter DRAIN_MAX, default 255, fence.i drain watchdog limit in cycles.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named as in the codebase.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 id_stall_req  in  1  load-use / CSR operand stall request from decode.
REQ-007 id_jump_ena  in  1  decode-stage redirect (JALR or branch mispredict).
REQ-008 id_fencei  in  1  valid FENCE.I currently in decode.
REQ-009 id_pc  in  PC_W  PC of the decode-stage instruction.
REQ-010 ex_busy  in  1  multi-cycle mul/div in execute, not finished.
REQ-011 ls_busy  in  1  load/store waiting on memory.
REQ-012 pipe_empty  in  1  EX, LS and WB hold no valid instruction.
REQ-013 ic_flush_done  in  1  one-cycle icache invalidate completion pulse.
REQ-014 stall_o  out  4  hold {LS,EX,ID,IF}, bit0 = IF.
REQ-015 flush_o  out  4  bubble insert {LS/WB,EX/LS,ID/EX,IF/ID}, bit0 = IF/ID.
REQ-016 ic_flush_req  out  1  icache invalidate request, level.
REQ-017 redir_ena  out  1  fence.i refetch redirect, one cycle.
REQ-018 redir_pc  out  PC_W  refetch target.
REQ-019 fencei_err  out  1  sticky drain-watchdog timeout flag.

Function
REQ-020 States: RUN, DRAIN, ICFLUSH, REDIR; registered, all other outputs combinational from state and inputs.
REQ-021 RUN priority 1: ls_busy -> stall_o = 4'b1111, flush_o = 0.
REQ-022 RUN priority 2: ex_busy -> stall_o = 4'b0111, flush_o = 4'b0100.
REQ-023 RUN priority 3: id_stall_req -> stall_o = 4'b0011, flush_o = 4'b0010; id_jump_ena SHALL be ignored in that cycle.
REQ-024 RUN priority 4: id_jump_ena -> stall_o = 0, flush_o = 4'b0001.
REQ-025 RUN: id_fencei with no higher-priority condition SHALL capture id_pc + 4 (mod 2^PC_W) into redir_pc, and go to DRAIN next cycle; the FENCE.I itself advances.
REQ-026 DRAIN: stall_o[1:0] = 2'b11, flush_o[1] = 1, LS/EX stall per ls_busy/ex_busy; pipe_empty -> ICFLUSH.
REQ-027 DRAIN: an 8-bit counter increments per cycle; reaching DRAIN_MAX sets fencei_err and forces ICFLUSH.
REQ-028 ICFLUSH: ic_flush_req = 1, stall_o = 4'b0011; ic_flush_done -> REDIR.
REQ-029 REDIR: redir_ena = 1, flush_o = 4'b0001, stall_o = 0 for exactly one cycle, then RUN.
REQ-030 id_jump_ena and id_fencei outside RUN SHALL be ignored.
REQ-031 redir_pc SHALL hold its value outside REDIR.
REQ-032 Latency: fence.i to redir_ena = 1 + drain cycles + icache flush cycles + 1.

Reset
REQ-033 rst = 0 at a clock edge SHALL force RUN, counter 0, redir_pc 0, and fencei_err 0, including mid-fence.i.
REQ-034 While in reset, stall_o = 0, flush_o = 0, ic_flush_req = 0, and redir_ena = 0.

Structure
REQ-035 State encodings, stall/flush bit indices and DRAIN_MAX default SHALL live in the shared define file.
REQ-036 The drain watchdog counter is the one natural sub-module: ysyx_22051013_hzd_wdog.

Verification
REQ-037 ls_busy = 1 and ex_busy = 1 together -> stall_o = 4'hF, flush_o = 0.
REQ-038 id_stall_req = 1 with id_jump_ena = 1 -> stall_o = 4'h3, flush_o = 4'h2; next cycle jump alone -> flush_o = 4'h1.
REQ-039 id_fencei with id_pc = 0x8000_0010, pipe_empty after 3 cycles, done after 2 -> redir_ena one cycle with redir_pc = 0x8000_0014.
REQ-040 id_pc = 0xFFFF_FFFF_FFFF_FFFC fence.i -> redir_pc = 0x0.
REQ-041 pipe_empty held 0 -> fencei_err = 1 after 255 DRAIN cycles, ic_flush_req then asserts.
REQ-042 rst = 0 during ICFLUSH -> next cycle RUN with all outputs 0.
